p_align_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational FP add/sub alignment block.
- Takes two IEEE-style operands, orders them by magnitude, and derives effective op and result sign.
- Right-shifts the smaller significand with guard/round/sticky (GRS) generation.
- Feeds the adder/normaliser stage through a valid/ready handshake with full backpressure; carries a user tag alongside each operation.

---
 rtl/p_align_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_p_align_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/p_align_pipe.sv
// p_align_pipe: two-stage pipelined FP add/sub alignment.
// S1 orders the operands by magnitude and derives the effective op, the
// result sign and the shift amount. S2 right-shifts the smaller significand
// and produces guard/round/sticky bits.
// Valid/ready handshake with full backpressure; a user tag rides with each op.
// Optional build macro: P_ALIGN_SPECIAL_EN enables NaN/Inf detection
// (out_nan/out_inf). Without it both flags are tied to 0.
module p_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic [EXP_W+MAN_W:0]   in2,
  input  logic                   op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign,
  output logic                   op_implied,
  output logic                   denormalA,
  output logic                   denormalB,
  output logic [EXP_W-1:0]       expA,
  output logic [EXP_W-1:0]       expB,
  output logic [MAN_W-1:0]       manA,
  output logic [MAN_W-1:0]       manB,
  output logic [MAN_W+4:0]       significand_grsA,
  output logic [MAN_W+4:0]       significand_grsB,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_nan,
  output logic                   out_inf
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;          // hidden bit + mantissa
  localparam int SH_MAX = MAN_W + 3;          // beyond this only sticky changes
  localparam int SHW    = SIG_W + SH_MAX;     // significand plus shift-out room

  // Handshake: a stage may load when empty or when its contents move on.
  logic w_s1_ready, w_s2_ready, w_in_fire;
  logic r_s1_valid, r_s2_valid;

  assign w_s2_ready = ~r_s2_valid | out_ready;
  assign w_s1_ready = ~r_s1_valid | w_s2_ready;
  assign w_in_fire  = in_valid & w_s1_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = r_s2_valid;

  // Stage 1 combinational: magnitude ordering and operand decode.
  logic             w_exchange;
  logic [W-1:0]     w_a, w_b;
  logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_diff, w_shamt;
  logic [MAN_W-1:0] w_man_a, w_man_b;
  logic             w_sign_a, w_sign_res, w_op_implied;
  logic             w_hidden_a, w_hidden_b, w_denorm_a, w_denorm_b;

  assign w_exchange   = in2[W-2:0] > in1[W-2:0];
  assign w_a          = w_exchange ? in2 : in1;
  assign w_b          = w_exchange ? in1 : in2;
  assign w_sign_a     = w_a[W-1];
  assign w_exp_a      = w_a[W-2:MAN_W];
  assign w_exp_b      = w_b[W-2:MAN_W];
  assign w_man_a      = w_a[MAN_W-1:0];
  assign w_man_b      = w_b[MAN_W-1:0];
  assign w_hidden_a   = |w_exp_a;
  assign w_hidden_b   = |w_exp_b;
  assign w_denorm_a   = (w_exp_a == '0) && (w_man_a != '0);
  assign w_denorm_b   = (w_exp_b == '0) && (w_man_b != '0);
  assign w_exp_diff   = w_exp_a - w_exp_b;
  // A denormal B sits at effective exponent 1, so it needs one less shift.
  assign w_shamt      = (w_denorm_b && !w_denorm_a) ? (w_exp_diff - EXP_W'(1)) : w_exp_diff;
  // After a swap the result of a subtraction takes the negated larger sign.
  assign w_sign_res   = (w_exchange && op) ? ~w_sign_a : w_sign_a;
  assign w_op_implied = op ^ in1[W-1] ^ in2[W-1];

  logic             r_s1_sign, r_s1_op_implied, r_s1_denorm_a, r_s1_denorm_b;
  logic             r_s1_hidden_a, r_s1_hidden_b;
  logic [EXP_W-1:0] r_s1_exp_a, r_s1_exp_b, r_s1_shamt;
  logic [MAN_W-1:0] r_s1_man_a, r_s1_man_b;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 1 register: capture decoded operands on an accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_sign       <= 1'b0;
      r_s1_op_implied <= 1'b0;
      r_s1_denorm_a   <= 1'b0;
      r_s1_denorm_b   <= 1'b0;
      r_s1_hidden_a   <= 1'b0;
      r_s1_hidden_b   <= 1'b0;
      r_s1_exp_a      <= '0;
      r_s1_exp_b      <= '0;
      r_s1_shamt      <= '0;
      r_s1_man_a      <= '0;
      r_s1_man_b      <= '0;
      r_s1_tag        <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign       <= w_sign_res;
        r_s1_op_implied <= w_op_implied;
        r_s1_denorm_a   <= w_denorm_a;
        r_s1_denorm_b   <= w_denorm_b;
        r_s1_hidden_a   <= w_hidden_a;
        r_s1_hidden_b   <= w_hidden_b;
        r_s1_exp_a      <= w_exp_a;
        r_s1_exp_b      <= w_exp_b;
        r_s1_shamt      <= w_shamt;
        r_s1_man_a      <= w_man_a;
        r_s1_man_b      <= w_man_b;
        r_s1_tag        <= in_tag;
      end
    end
  end

  // Stage 2 combinational: saturating alignment shift with GRS extraction.
  logic [31:0]      w_shamt_used;
  logic [SHW-1:0]   w_shift_in, w_shifted;
  logic [MAN_W+4:0] w_grs_a, w_grs_b;

  assign w_shamt_used = (32'(r_s1_shamt) > 32'(SH_MAX)) ? 32'(SH_MAX) : 32'(r_s1_shamt);
  assign w_shift_in   = {r_s1_hidden_b, r_s1_man_b, {SH_MAX{1'b0}}};
  assign w_shifted    = w_shift_in >> w_shamt_used;
  assign w_grs_a      = {1'b0, r_s1_hidden_a, r_s1_man_a, 3'b000};
  assign w_grs_b      = {1'b0, w_shifted[SHW-1 -: SIG_W], w_shifted[SH_MAX-1],
                         w_shifted[SH_MAX-2], |w_shifted[SH_MAX-3:0]};

  // Stage 2 register: output holding register, frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid       <= 1'b0;
      sign             <= 1'b0;
      op_implied       <= 1'b0;
      denormalA        <= 1'b0;
      denormalB        <= 1'b0;
      expA             <= '0;
      expB             <= '0;
      manA             <= '0;
      manB             <= '0;
      significand_grsA <= '0;
      significand_grsB <= '0;
      out_tag          <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        sign             <= r_s1_sign;
        op_implied       <= r_s1_op_implied;
        denormalA        <= r_s1_denorm_a;
        denormalB        <= r_s1_denorm_b;
        expA             <= r_s1_exp_a;
        expB             <= r_s1_exp_b;
        manA             <= r_s1_man_a;
        manB             <= r_s1_man_b;
        significand_grsA <= w_grs_a;
        significand_grsB <= w_grs_b;
        out_tag          <= r_s1_tag;
      end
    end
  end

`ifdef P_ALIGN_SPECIAL_EN
  // Special-value decode; flags travel with the datapath through both stages.
  logic w_max_a, w_max_b, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_nan, w_inf;
  logic r_s1_nan, r_s1_inf;

  assign w_max_a = &w_exp_a;
  assign w_max_b = &w_exp_b;
  assign w_nan_a = w_max_a & (|w_man_a);
  assign w_nan_b = w_max_b & (|w_man_b);
  assign w_inf_a = w_max_a & ~(|w_man_a);
  assign w_inf_b = w_max_b & ~(|w_man_b);
  assign w_nan   = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & w_op_implied);
  assign w_inf   = (w_inf_a | w_inf_b) & ~w_nan;

  // Stage 1 special flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_nan <= 1'b0;
      r_s1_inf <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_nan <= w_nan;
      r_s1_inf <= w_inf;
    end
  end

  // Stage 2 special flags, held with the rest of the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_nan <= 1'b0;
      out_inf <= 1'b0;
    end else if (w_s2_ready && r_s1_valid) begin
      out_nan <= r_s1_nan;
      out_inf <= r_s1_inf;
    end
  end
`else
  assign out_nan = 1'b0;
  assign out_inf = 1'b0;
`endif

endmodule

// File: tb/tb_p_align_pipe.sv
// Scoreboard bench for p_align_pipe: the driver pushes hand-computed
// expectations when an input is accepted; a monitor pops and compares
// whenever an output transfers.
module tb_p_align_pipe;

`ifdef P_ALIGN_SPECIAL_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] in1, in2;
  logic [3:0]  in_tag, out_tag;
  logic        sign, op_implied, denormalA, denormalB, out_nan, out_inf;
  logic [7:0]  expA, expB;
  logic [22:0] manA, manB;
  logic [27:0] significand_grsA, significand_grsB;

  always #5 clk = ~clk;

  p_align_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .op_implied(op_implied), .denormalA(denormalA), .denormalB(denormalB),
    .expA(expA), .expB(expB), .manA(manA), .manB(manB),
    .significand_grsA(significand_grsA), .significand_grsB(significand_grsB),
    .out_tag(out_tag), .out_nan(out_nan), .out_inf(out_inf)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [3:0]  tag;
    logic        sign, opi, dA, dB;
    logic [7:0]  eA, eB;
    logic [22:0] mA, mB;
    logic [27:0] gA, gB;
    logic        inf;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t v[13];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic o,
                              input logic [3:0] t, input logic s, input logic oi,
                              input logic da, input logic db, input logic [7:0] ea,
                              input logic [7:0] eb, input logic [22:0] ma, input logic [22:0] mb,
                              input logic [27:0] ga, input logic [27:0] gb, input logic inf);
    exp_t e;
    e.a = a; e.b = b; e.op = o; e.tag = t; e.sign = s; e.opi = oi; e.dA = da; e.dB = db;
    e.eA = ea; e.eB = eb; e.mA = ma; e.mB = mb; e.gA = ga; e.gB = gb; e.inf = inf;
    e.acc_cyc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Drive one operation; push its expectation at the accepting edge.
  task automatic send(input exp_t e, input bit lat);
    int waited = 0;
    @(negedge clk);
    in1 = e.a; in2 = e.b; op = e.op; in_tag = e.tag; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
    end else begin
      e.acc_cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: compare every transferred result against the queue head.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_output", out_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        n_out++;
        $display("OUT tag=%0h sign=%0b opi=%0b expA=%0h expB=%0h grsA=%0h grsB=%0h",
                 out_tag, sign, op_implied, expA, expB, significand_grsA, significand_grsB);
        chk("tag", out_tag, mon_e.tag);
        chk("sign", sign, mon_e.sign);
        chk("op_implied", op_implied, mon_e.opi);
        chk("denormals", {denormalA, denormalB}, {mon_e.dA, mon_e.dB});
        chk("exps", {expA, expB}, {mon_e.eA, mon_e.eB});
        chk("mans", {manA, manB}, {mon_e.mA, mon_e.mB});
        chk("significand_grsA", significand_grsA, mon_e.gA);
        chk("significand_grsB", significand_grsB, mon_e.gB);
        chk("special", {out_nan, out_inf}, {1'b0, mon_e.inf});
        if (mon_e.lat) chk("latency", cyc - mon_e.acc_cyc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            in1           in2           op   tag   s     opi   dA    dB    eA     eB     mA          mB         gA            gB            inf
    v[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h4000000, 1'b0);
    v[1]  = mk(32'h3F800000, 32'h40000000, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h2000000, 1'b0);
    v[2]  = mk(32'h4B800000, 32'h3F800001, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h97, 8'h7F, 23'h0,      23'h1,     28'h4000000, 28'h0000005, 1'b0);
    v[3]  = mk(32'h00800000, 32'h00000001, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 23'h0,      23'h1,     28'h4000000, 28'h0000008, 1'b0);
    v[4]  = mk(32'hC0400000, 32'h3F800000, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h7F, 23'h400000, 23'h0,     28'h6000000, 28'h2000000, 1'b0);
    v[5]  = mk(32'h3F800000, 32'hC0000000, 1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h2000000, 1'b0);
    v[6]  = mk(32'h3F800000, 32'hC0000000, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h2000000, 1'b0);
    v[7]  = mk(32'h7F000000, 32'h3F800000, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h0000001, 1'b0);
    v[8]  = mk(32'h4C000000, 32'h3F800000, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h98, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h0000002, 1'b0);
    v[9]  = mk(32'h00000003, 32'h00000002, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 23'h3,      23'h2,     28'h0000018, 28'h0000010, 1'b0);
    v[10] = mk(32'hBF800000, 32'h3F800000, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h4000000, 1'b0);
    v[11] = mk(32'h3F800000, 32'h00000000, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 23'h0,      23'h0,     28'h4000000, 28'h0000000, 1'b0);
    v[12] = mk(32'h7F800000, 32'h3F800000, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h7F, 23'h0,      23'h0,     28'h4000000, 28'h0000001, SPEC);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0;
    in1 = '0; in2 = '0; in_tag = '0;

    // Reset defaults.
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {sign, op_implied, denormalA, denormalB, expA, expB, manA, manB,
                          significand_grsA, significand_grsB, out_tag, out_nan, out_inf}, 128'd0);

    // Back-to-back directed vectors with no stall: latency 2, one per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) send(v[i], 1'b1);
    wait_drain();

    // Backpressure: two accepted, third refused, output frozen.
    out_ready = 1'b0;
    base = n_out;
    send(v[4], 1'b0);
    send(v[9], 1'b0);
    @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h3F800000; op = 1'b0; in_tag = 4'hF; in_valid = 1'b1;
    #1 chk("bp_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      chk("bp_in_ready_hold", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_tag_stable", out_tag, v[4].tag);
      chk("bp_grsB_stable", significand_grsB, v[4].gB);
    end
    in_valid = 1'b0;
    @(negedge clk) out_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("bp_result_count", n_out - base, 2);

    // Reset with both stages full: nothing stale may emerge.
    out_ready = 1'b0;
    send(v[0], 1'b0);
    send(v[1], 1'b0);
    @(negedge clk) rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    base = n_out;
    repeat (6) @(negedge clk);
    #2;
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_no_stale", n_out - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
